// File: rtl/arc4_pkg.sv
// rtl/arc4_pkg.sv - shared ARC4 types and constants: plaintext checker states, length address, printable bounds
package arc4_pkg;

    localparam logic [7:0] LEN_ADDR = 8'd0;
    localparam logic [7:0] PRINT_LO = 8'h20;
    localparam logic [7:0] PRINT_HI = 8'h7E;

    // PT_ prefix keeps the state names clear of the LEN_ADDR address constant
    typedef enum logic [2:0] {
        PT_IDLE,
        PT_LEN_ADDR,
        PT_LEN_DATA,
        PT_BYTE_ADDR,
        PT_BYTE_DATA,
        PT_DONE
    } pt_state_e;

endpackage

// File: rtl/byte_in_range.sv
// rtl/byte_in_range.sv - combinational inclusive unsigned range compare LO <= byte <= HI
module byte_in_range
    import arc4_pkg::*;
#(
    parameter logic [7:0] LO = PRINT_LO,
    parameter logic [7:0] HI = PRINT_HI
) (
    input  logic [7:0] byte_i,
    output logic       in_range_o
);

    assign in_range_o = (byte_i >= LO) && (byte_i <= HI);

endmodule

// File: rtl/pt_checker.sv
// rtl/pt_checker.sv - walks a length-prefixed plaintext buffer and flags non-printable bytes (option: PTCHK_ERRCNT_EN)
module pt_checker
    import arc4_pkg::*;
#(
    parameter logic [7:0] LO = PRINT_LO,
    parameter logic [7:0] HI = PRINT_HI
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    output logic       rdy,
    output logic [7:0] pt_addr,
    input  logic [7:0] pt_rddata,
    output logic       valid,
`ifdef PTCHK_ERRCNT_EN
    output logic [7:0] err_count,
`endif
    output logic [7:0] bad_addr
);

    pt_state_e  state_q;
    logic       rdy_q;
    logic [7:0] pt_addr_q;
    logic       valid_q;
    logic [7:0] bad_addr_q;
    logic [7:0] len_q;
    logic [7:0] idx_q;
    logic [7:0] idx_d;
    logic       fail_q;
    logic       in_range;
    logic       last_byte;

    byte_in_range #(.LO(LO), .HI(HI)) u_range (
        .byte_i     (pt_rddata),
        .in_range_o (in_range)
    );

    assign idx_d = idx_q + 8'd1;

`ifdef PTCHK_ERRCNT_EN
    logic [7:0] err_q;
    assign err_count = err_q;
    assign last_byte = (idx_q == len_q);
`else
    assign last_byte = !in_range || (idx_q == len_q);
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= PT_IDLE;
            rdy_q      <= 1'b1;
            pt_addr_q  <= LEN_ADDR;
            valid_q    <= 1'b0;
            bad_addr_q <= 8'd0;
            len_q      <= 8'd0;
            idx_q      <= 8'd0;
            fail_q     <= 1'b0;
`ifdef PTCHK_ERRCNT_EN
            err_q      <= 8'd0;
`endif
        end else begin
            case (state_q)
                PT_IDLE: begin
                    if (en) begin
                        rdy_q      <= 1'b0;
                        valid_q    <= 1'b0;
                        bad_addr_q <= 8'd0;
                        fail_q     <= 1'b0;
`ifdef PTCHK_ERRCNT_EN
                        err_q      <= 8'd0;
`endif
                        pt_addr_q  <= LEN_ADDR;
                        state_q    <= PT_LEN_ADDR;
                    end
                end
                PT_LEN_ADDR: state_q <= PT_LEN_DATA;
                PT_LEN_DATA: begin
                    len_q <= pt_rddata;
                    if (pt_rddata == 8'd0) begin
                        state_q <= PT_DONE;
                    end else begin
                        pt_addr_q <= 8'd1;
                        idx_q     <= 8'd1;
                        state_q   <= PT_BYTE_ADDR;
                    end
                end
                PT_BYTE_ADDR: state_q <= PT_BYTE_DATA;
                PT_BYTE_DATA: begin
                    if (!in_range) begin
                        // only the first offender is reported, even when the walk continues
                        if (!fail_q) begin
                            bad_addr_q <= idx_q;
                        end
                        fail_q <= 1'b1;
`ifdef PTCHK_ERRCNT_EN
                        err_q  <= err_q + 8'd1;
`endif
                    end
                    if (last_byte) begin
                        state_q <= PT_DONE;
                    end else begin
                        idx_q     <= idx_d;
                        pt_addr_q <= idx_d;
                        state_q   <= PT_BYTE_ADDR;
                    end
                end
                PT_DONE: begin
                    rdy_q   <= 1'b1;
                    valid_q <= !fail_q;
                    state_q <= PT_IDLE;
                end
                default: state_q <= PT_IDLE;
            endcase
        end
    end

    assign rdy      = rdy_q;
    assign pt_addr  = pt_addr_q;
    assign valid    = valid_q;
    assign bad_addr = bad_addr_q;

endmodule

// File: tb/tb_pt_checker.sv
// tb/tb_pt_checker.sv - scoreboard bench for pt_checker: results, latency and address walk per run
module tb_pt_checker;
    import arc4_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       rdy;
    logic [7:0] pt_addr;
    logic [7:0] pt_rddata;
    logic       valid;
    logic [7:0] bad_addr;
`ifdef PTCHK_ERRCNT_EN
    logic [7:0] err_count;
`endif

    logic [7:0] mem [0:255];
    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic       v;
        logic [7:0] bad;
        logic [7:0] errs;
        int         lat;
        int         naddr;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] addr_seq[$];
    bit         rec = 1'b0;

    pt_checker dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .rdy       (rdy),
        .pt_addr   (pt_addr),
        .pt_rddata (pt_rddata),
        .valid     (valid),
`ifdef PTCHK_ERRCNT_EN
        .err_count (err_count),
`endif
        .bad_addr  (bad_addr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) pt_rddata <= mem[pt_addr];

    always @(negedge clk) begin
        if (rec && (addr_seq.size() == 0 || addr_seq[$] != pt_addr)) begin
            addr_seq.push_back(pt_addr);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [7:0] b[$]);
        foreach (b[i]) mem[i] = b[i];
    endtask

    function automatic exp_t model();
        exp_t e;
        int   len;
        int   k;
        len    = int'(mem[0]);
        e.v    = 1'b1;
        e.bad  = 8'd0;
        e.errs = 8'd0;
        k      = len;
        for (int i = 1; i <= len; i++) begin
            if (mem[i] < 8'h20 || mem[i] > 8'h7E) begin
                e.errs = e.errs + 8'd1;
                if (e.errs == 8'd1) begin
                    e.bad = i[7:0];
                    e.v   = 1'b0;
`ifndef PTCHK_ERRCNT_EN
                    k = i;
`endif
                end
            end
        end
        e.lat   = 2 * (k + 1) + 1;
        e.naddr = k + 1;
        return e;
    endfunction

    task automatic run(input string tag, input bit hold_en);
        exp_t got;
        int   cyc;
        bit   seq_ok;
        exp_q.push_back(model());
        @(negedge clk);
        en = 1'b1;
        addr_seq.delete();
        @(posedge clk);
        #1;
        if (!hold_en) en = 1'b0;
        rec = 1'b1;
        cyc = 0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
        end while (!rdy && cyc < 1000);
        en  = 1'b0;
        rec = 1'b0;
        got = exp_q.pop_front();
        chk({tag, ".rdy"}, 32'(rdy), 32'd1);
        chk({tag, ".lat"}, cyc, got.lat);
        chk({tag, ".valid"}, 32'(valid), 32'(got.v));
        chk({tag, ".bad_addr"}, 32'(bad_addr), 32'(got.bad));
`ifdef PTCHK_ERRCNT_EN
        chk({tag, ".err_count"}, 32'(err_count), 32'(got.errs));
`endif
        chk({tag, ".naddr"}, addr_seq.size(), got.naddr);
        seq_ok = 1'b1;
        foreach (addr_seq[i]) if (int'(addr_seq[i]) != i) seq_ok = 1'b0;
        chk({tag, ".addr_seq"}, 32'(seq_ok), 32'd1);
    endtask

    initial begin
        logic [7:0] q[$];
        for (int i = 0; i < 256; i++) mem[i] = 8'h41;

        // reset with en held high must leave the block idle
        rst_n = 1'b0;
        en    = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.rdy", 32'(rdy), 32'd1);
        chk("rst.valid", 32'(valid), 32'd0);
        chk("rst.bad_addr", 32'(bad_addr), 32'd0);
        chk("rst.pt_addr", 32'(pt_addr), 32'd0);
`ifdef PTCHK_ERRCNT_EN
        chk("rst.err_count", 32'(err_count), 32'd0);
`endif
        en    = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("idle.rdy", 32'(rdy), 32'd1);

        q = '{8'd5, 8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F};
        load(q);
        run("hello", 1'b0);

        q = '{8'd4, 8'h41, 8'h0A, 8'h42, 8'h43};
        load(q);
        run("early", 1'b1);

        q = '{8'd4, 8'h20, 8'h7E, 8'h20, 8'h7E};
        load(q);
        run("bnd_pass", 1'b0);

        q = '{8'd2, 8'h20, 8'h1F};
        load(q);
        run("bnd_1f", 1'b0);

        q = '{8'd3, 8'h7E, 8'h7E, 8'h7F};
        load(q);
        run("bnd_7f", 1'b0);

        q = '{8'd0};
        load(q);
        run("len0", 1'b0);

        // abort an L=200 walk while it sits in BYTE_DATA (after odd edges)
        for (int i = 1; i < 256; i++) mem[i] = 8'h41;
        mem[0] = 8'd200;
        @(negedge clk);
        en = 1'b1;
        @(posedge clk);
        #1;
        en = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        chk("midrst.busy", 32'(rdy), 32'd0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst.rdy", 32'(rdy), 32'd1);
        chk("midrst.valid", 32'(valid), 32'd0);
        chk("midrst.bad_addr", 32'(bad_addr), 32'd0);
        chk("midrst.pt_addr", 32'(pt_addr), 32'd0);
        rst_n = 1'b1;

        run("full200", 1'b0);

        mem[150] = 8'hFF;
        run("fail150", 1'b0);

        mem[150] = 8'h41;
        mem[0]   = 8'd255;
        run("len255", 1'b1);

`ifdef PTCHK_ERRCNT_EN
        q = '{8'd6, 8'h61, 8'h01, 8'h62, 8'h02, 8'hFF, 8'h63};
        load(q);
        run("errcnt", 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/pt_checker.md
Name: pt_checker

Overview:
- Reader at the far end of the plaintext memory that the PRGA writes.
- Walks a length-prefixed plaintext buffer: address 0 holds length L, addresses 1..L hold message bytes.
- Reports whether every message byte lies in a printable range.
- Used by the key-search controller to accept or reject a candidate key after each PRGA run.
- Uses the same rdy/en handshake as the other ARC4 blocks.

Parameters:
- LO, 8'h20, lowest acceptable byte value (inclusive).
- HI, 8'h7E, highest acceptable byte value (inclusive).

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset; one clock; reset is synchronous and active-low
- en  input  1  start request; sampled only while rdy=1
- rdy  output  1  block idle and ready to accept en
- pt_addr  output  8  plaintext memory read address
- pt_rddata  input  8  plaintext memory read data; synchronous memory, valid the cycle after pt_addr is presented
- valid  output  1  1 = last completed check passed
- bad_addr  output  8  address of first failing byte; 0 when valid=1

Behaviour:
- Reset values (rst_n low at a clk edge): rdy=1, pt_addr=0, valid=0, bad_addr=0, state=IDLE.
- Reset mid-operation aborts the check and returns to IDLE with the reset values on the next edge.
- Handshake:
  - Start is accepted on the edge where rdy=1 and en=1; rdy=0 from the next cycle.
  - en while rdy=0 is ignored.
  - valid and bad_addr hold the previous result until the next accept; both clear to 0 on accept.
- States: IDLE, LEN_ADDR, LEN_DATA, BYTE_ADDR, BYTE_DATA, DONE.
- IDLE: on accept, pt_addr<=0, go to LEN_ADDR.
- LEN_ADDR: one wait cycle for the memory read; go to LEN_DATA.
- LEN_DATA: capture len<=pt_rddata.
  - If len==0, go to DONE with pass.
  - Otherwise pt_addr<=1, idx<=1, go to BYTE_ADDR.
- BYTE_ADDR: one wait cycle; go to BYTE_DATA.
- BYTE_DATA: test LO<=pt_rddata<=HI.
  - Fail: record bad_addr<=idx, result fail, go to DONE (early exit).
  - Pass with idx==len: result pass, go to DONE.
  - Pass otherwise: idx<=idx+1, pt_addr<=idx+1, go to BYTE_ADDR.
- DONE: drive valid (1 for pass, 0 for fail) and bad_addr; rdy=1 from the next cycle; return to IDLE.
- Latency, with cycle 0 = accepting edge:
  - rdy reasserts 2*(k+1)+1 cycles after accept.
  - k = index of the first failing byte, or k = L if all bytes pass.
  - L=0 gives 3 cycles.
- Widths:
  - idx and len are 8 bits unsigned; L=255 is legal.
  - idx never wraps because the comparison with len terminates the walk first.
- The comparison is unsigned; bytes equal to LO or HI pass.
- pt_addr holds its last value while in IDLE.

Optional Feature:
- Macro: PTCHK_ERRCNT_EN.
- When defined:
  - Adds output err_count[7:0].
  - Disables early exit: all L bytes are always read, and rdy reasserts 2*(L+1)+1 cycles after accept.
  - err_count is the number of out-of-range bytes; it clears on accept and is 0 at reset.
  - bad_addr is still the first failing address.
- When undefined: no err_count port, and early exit applies as above.

Decomposition:
- Shared package arc4_pkg holds:
  - the state enum typedef for this block;
  - constant LEN_ADDR=8'd0;
  - default printable bounds PRINT_LO=8'h20 and PRINT_HI=8'h7E, used as the parameter defaults.
- One natural sub-module: byte_in_range, a combinational range compare parameterized by LO and HI.
- The FSM, counters and result registers stay in pt_checker.

Test Plan:
- Reset then idle: hold rst_n=0 for 2 edges -> rdy=1, valid=0, bad_addr=0, pt_addr=0; en while in reset has no effect.
- Pass case: memory {8'd5,"Hello"}, pulse en -> rdy reasserts 13 cycles after accept, valid=1, bad_addr=0; pt_addr sequence 0,1,2,3,4,5.
- Early fail: memory {8'd4,8'h41,8'h0A,8'h42,8'h43} -> bad_addr=2, valid=0, rdy back after 7 cycles; addresses 3 and 4 are never presented.
- Boundaries: bytes 8'h20 and 8'h7E pass; 8'h1F and 8'h7F fail. Also L=0 -> valid=1 after 3 cycles, only address 0 read.
- Reset mid-check: assert rst_n=0 during BYTE_DATA of an L=200 run -> next edge rdy=1, valid=0. A new en then runs a full check correctly.
- With PTCHK_ERRCNT_EN: memory {8'd6,"a",8'h01,"b",8'h02,8'hFF,"c"} -> err_count=3, bad_addr=2, valid=0, rdy after 15 cycles.
